alu_exec_unit: RTL and testbench

//  Parametrised EX-stage execution unit: decodes ALUOp/funct internally and executes the op.

---
 rtl/alu_exec_unit.sv | 210 +++++++++++++++++++++
 tb/tb_alu_exec_unit.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// EX-stage execution unit. ALUOp/funct are decoded here. Single-cycle ops
// finish at the accepting edge. MUL/MULU/DIV/DIVU iterate one bit per cycle
// on operand magnitudes, and the sign is fixed up in a final FIX cycle.
module alu_exec_unit #(
  parameter int WIDTH         = 32,
  parameter bit ENABLE_MULDIV = 1'b1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             kill_i,
  input  logic [1:0]       ALUOp_i,
  input  logic [5:0]       funct_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             ready_o,
  output logic             valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] hi_o,
  output logic             zero_o,
  output logic             illegal_o,
  output logic             div_zero_o
);

  localparam int            CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [3:0] {
    OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SLT,
    OP_MUL, OP_MULU, OP_DIV, OP_DIVU, OP_ILL
  } op_e;

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_e;

  typedef struct packed {
    op_e  op;
    logic multi;   // iterative mul/div
    logic is_div;
    logic sgn;     // signed variant (MUL/DIV)
  } dec_t;

  dec_t             dec;
  state_e           state;
  logic             accept;
  logic [WIDTH-1:0] sc_res;
  logic [WIDTH-1:0] a_mag, b_mag;

  // iterative datapath state
  logic             is_div_q, neg_lo, neg_hi, dz;
  logic [WIDTH-1:0] dvd, opnd, acc_hi, acc_lo;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]     mul_sum, div_sh, div_df;
  logic               div_ge;
  logic [WIDTH-1:0]   step_hi, step_lo, fix_hi, fix_lo;
  logic [2*WIDTH-1:0] fix_prod;

  assign ready_o = (state == S_IDLE);
  assign accept  = valid_i && ready_o && !kill_i;

  // Decode ALUOp/funct. Start from illegal so an unknown code never reuses old control.
  always_comb begin
    dec = '{op: OP_ILL, multi: 1'b0, is_div: 1'b0, sgn: 1'b0};
    case (ALUOp_i)
      2'b00:   dec.op = OP_ADD;
      2'b01:   dec.op = OP_SUB;
      2'b10:   dec.op = OP_OR;
      default: begin
        case (funct_i)
          6'b100000: dec.op = OP_ADD;
          6'b100010: dec.op = OP_SUB;
          6'b100100: dec.op = OP_AND;
          6'b100101: dec.op = OP_OR;
          6'b100110: dec.op = OP_XOR;
          6'b101010: dec.op = OP_SLT;
          6'b011000: if (ENABLE_MULDIV) dec.op = OP_MUL;
          6'b011001: if (ENABLE_MULDIV) dec.op = OP_MULU;
          6'b011010: if (ENABLE_MULDIV) dec.op = OP_DIV;
          6'b011011: if (ENABLE_MULDIV) dec.op = OP_DIVU;
          default:   dec.op = OP_ILL;
        endcase
      end
    endcase
    dec.multi  = dec.op inside {OP_MUL, OP_MULU, OP_DIV, OP_DIVU};
    dec.is_div = dec.op inside {OP_DIV, OP_DIVU};
    dec.sgn    = dec.op inside {OP_MUL, OP_DIV};
  end

  // Single-cycle result. Illegal ops yield 0.
  always_comb begin
    sc_res = '0;
    case (dec.op)
      OP_ADD:  sc_res = a_i + b_i;
      OP_SUB:  sc_res = a_i - b_i;
      OP_AND:  sc_res = a_i & b_i;
      OP_OR:   sc_res = a_i | b_i;
      OP_XOR:  sc_res = a_i ^ b_i;
      OP_SLT:  sc_res = {{(WIDTH-1){1'b0}}, ($signed(a_i) < $signed(b_i))};
      default: sc_res = '0;
    endcase
  end

  // Operand magnitudes. The iteration is unsigned, and signed ops negate back in FIX.
  assign a_mag = (dec.sgn && a_i[WIDTH-1]) ? -a_i : a_i;
  assign b_mag = (dec.sgn && b_i[WIDTH-1]) ? -b_i : b_i;

  // One iteration step: shift-add multiply or restoring divide on {acc_hi,acc_lo}.
  always_comb begin
    mul_sum = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, opnd} : '0);
    div_sh  = {acc_hi, acc_lo[WIDTH-1]};
    div_ge  = (div_sh >= {1'b0, opnd});
    div_df  = div_sh - {1'b0, opnd};
    if (is_div_q) begin
      step_hi = div_ge ? div_df[WIDTH-1:0] : div_sh[WIDTH-1:0];
      step_lo = {acc_lo[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo[WIDTH-1:1]};
    end
  end

  // Sign correction and the divide-by-zero override applied in FIX.
  always_comb begin
    fix_prod = neg_lo ? -{acc_hi, acc_lo} : {acc_hi, acc_lo};
    fix_hi   = fix_prod[2*WIDTH-1:WIDTH];
    fix_lo   = fix_prod[WIDTH-1:0];
    if (is_div_q) begin
      if (dz) begin
        fix_lo = '1;
        fix_hi = dvd;
      end else begin
        fix_lo = neg_lo ? -acc_lo : acc_lo;
        fix_hi = neg_hi ? -acc_hi : acc_hi;
      end
    end
  end

  // Control FSM with registered results. Outputs hold their values between valid_o pulses.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= S_IDLE;
      valid_o    <= 1'b0;
      result_o   <= '0;
      hi_o       <= '0;
      zero_o     <= 1'b0;
      illegal_o  <= 1'b0;
      div_zero_o <= 1'b0;
      is_div_q   <= 1'b0;
      neg_lo     <= 1'b0;
      neg_hi     <= 1'b0;
      dz         <= 1'b0;
      dvd        <= '0;
      opnd       <= '0;
      acc_hi     <= '0;
      acc_lo     <= '0;
      cnt        <= '0;
    end else begin
      valid_o <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            if (dec.multi) begin
              state    <= S_CALC;
              cnt      <= '0;
              is_div_q <= dec.is_div;
              neg_lo   <= dec.sgn && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
              neg_hi   <= dec.sgn && a_i[WIDTH-1];
              dz       <= dec.is_div && (b_i == '0);
              dvd      <= a_i;
              acc_hi   <= '0;
              // div shifts the dividend out of acc_lo; mul shifts the multiplier
              acc_lo   <= dec.is_div ? a_mag : b_mag;
              opnd     <= dec.is_div ? b_mag : a_mag;
            end else begin
              valid_o    <= 1'b1;
              result_o   <= sc_res;
              hi_o       <= '0;
              zero_o     <= (sc_res == '0);
              illegal_o  <= (dec.op == OP_ILL);
              div_zero_o <= 1'b0;
            end
          end
        end
        S_CALC: begin
          if (kill_i) begin
            state <= S_IDLE;
          end else begin
            acc_hi <= step_hi;
            acc_lo <= step_lo;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) state <= S_FIX;
          end
        end
        S_FIX: begin
          state <= S_IDLE;
          if (!kill_i) begin
            valid_o    <= 1'b1;
            result_o   <= fix_lo;
            hi_o       <= fix_hi;
            zero_o     <= (fix_lo == '0);
            illegal_o  <= 1'b0;
            div_zero_o <= dz;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Randomized and directed bench for alu_exec_unit. Expected values come from
// plain 64-bit arithmetic and not from the iterative algorithm.
module tb_alu_exec_unit;
  localparam int W = 32;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100,
                         F_OR  = 6'b100101, F_XOR = 6'b100110, F_SLT = 6'b101010,
                         F_MUL = 6'b011000, F_MULU = 6'b011001, F_DIV = 6'b011010,
                         F_DIVU = 6'b011011, F_BAD = 6'b111111;

  logic clk = 1'b0, rst = 1'b1, valid = 1'b0, kill = 1'b0;
  logic [1:0] aluop = '0;
  logic [5:0] funct = '0;
  logic [W-1:0] a = '0, b = '0;

  logic ready, vo, zr, ill, dz;
  logic [W-1:0] res, hi;
  logic nm_ready, nm_vo, nm_zr, nm_ill, nm_dz;
  logic [W-1:0] nm_res, nm_hi;

  typedef struct packed {
    logic vld, ill, dz, zero;
    logic [W-1:0] hi, lo;
  } pk_t;

  typedef struct packed {
    pk_t r;
    int  lat;   // edges after the accepting edge until valid_o is seen
    int  busy;  // sampled cycles with ready_o low
  } exp_t;

  typedef struct packed {
    logic [1:0] op;
    logic [5:0] fn;
    logic [W-1:0] a, b, hi, lo;
  } vec_t;

  int n_vec = 0, n_err = 0;

  always #5 clk = ~clk;

  alu_exec_unit #(.WIDTH(W), .ENABLE_MULDIV(1'b1)) u_dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .kill_i(kill), .ALUOp_i(aluop),
    .funct_i(funct), .a_i(a), .b_i(b), .ready_o(ready), .valid_o(vo),
    .result_o(res), .hi_o(hi), .zero_o(zr), .illegal_o(ill), .div_zero_o(dz));

  alu_exec_unit #(.WIDTH(W), .ENABLE_MULDIV(1'b0)) u_nomd (
    .clk_i(clk), .rst_i(rst), .valid_i(valid), .kill_i(kill), .ALUOp_i(aluop),
    .funct_i(funct), .a_i(a), .b_i(b), .ready_o(nm_ready), .valid_o(nm_vo),
    .result_o(nm_res), .hi_o(nm_hi), .zero_o(nm_zr), .illegal_o(nm_ill), .div_zero_o(nm_dz));

  // Reference: what the op must produce, from plain arithmetic.
  function automatic exp_t model(input logic [1:0] op, input logic [5:0] fn,
                                 input logic [W-1:0] x, input logic [W-1:0] y, input bit md);
    exp_t e;
    logic [5:0] f;
    logic signed [63:0] sx, sy, sp, sq, sr;
    logic [63:0] up;
    e = '0;
    e.r.vld = 1'b1;
    f = (op == 2'b00) ? F_ADD : (op == 2'b01) ? F_SUB : (op == 2'b10) ? F_OR : fn;
    if (!md && (f inside {F_MUL, F_MULU, F_DIV, F_DIVU})) f = F_BAD;
    sx = {{32{x[W-1]}}, x};
    sy = {{32{y[W-1]}}, y};
    if (f inside {F_MUL, F_MULU, F_DIV, F_DIVU}) begin
      e.lat  = W + 1;
      e.busy = W + 1;
    end
    case (f)
      F_ADD: e.r.lo = x + y;
      F_SUB: e.r.lo = x - y;
      F_AND: e.r.lo = x & y;
      F_OR:  e.r.lo = x | y;
      F_XOR: e.r.lo = x ^ y;
      F_SLT: e.r.lo = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
      F_MUL: begin sp = sx * sy; {e.r.hi, e.r.lo} = sp; end
      F_MULU: begin up = {32'd0, x} * {32'd0, y}; {e.r.hi, e.r.lo} = up; end
      F_DIV, F_DIVU: begin
        if (y == '0) begin
          e.r.dz = 1'b1; e.r.lo = '1; e.r.hi = x;
        end else if (f == F_DIV) begin
          sq = sx / sy; sr = sx % sy;
          e.r.lo = sq[W-1:0]; e.r.hi = sr[W-1:0];
        end else begin
          e.r.lo = x / y; e.r.hi = x % y;
        end
      end
      default: e.r.ill = 1'b1;
    endcase
    e.r.zero = (e.r.lo == '0);
    return e;
  endfunction

  // Drive one op from an idle DUT and collect what comes out (no checking here).
  task automatic run_op(input logic [1:0] op, input logic [5:0] fn, input logic [W-1:0] x,
                        input logic [W-1:0] y, input bit nm, output exp_t o);
    aluop = op; funct = fn; a = x; b = y; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    o = '0;
    while (!(nm ? nm_vo : vo) && o.lat < 100) begin
      if (!(nm ? nm_ready : ready)) o.busy++;
      @(posedge clk); #1;
      o.lat++;
    end
    if (nm) o.r = '{nm_vo, nm_ill, nm_dz, nm_zr, nm_hi, nm_res};
    else    o.r = '{vo, ill, dz, zr, hi, res};
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return 32'h8000_0000;
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  task automatic test_reset();
    #2;
    n_vec++;
    if ({ready, vo, ill, dz, zr, hi, res, nm_ready} !== {1'b1, 4'b0, 64'd0, 1'b1}) begin
      n_err++;
      $display("FAIL reset_state: got rdy=%b v=%b ill=%b dz=%b z=%b hi=%h res=%h, need rdy=1 rest 0",
               ready, vo, ill, dz, zr, hi, res);
    end
    #10 rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    vec_t tbl [12];
    exp_t o, e;
    tbl = '{
      '{2'b11, F_ADD,  32'd5,         32'd7,         32'd0,         32'd12},
      '{2'b01, F_BAD,  32'd9,         32'd9,         32'd0,         32'd0},
      '{2'b11, F_MUL,  32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFE},
      '{2'b11, F_MULU, 32'hFFFF_FFFF, 32'd2,         32'd1,         32'hFFFF_FFFE},
      '{2'b11, F_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD},
      '{2'b11, F_DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF},
      '{2'b11, F_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000},
      '{2'b11, F_BAD,  32'd3,         32'd4,         32'd0,         32'd0},
      '{2'b00, F_BAD,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd0},
      '{2'b11, F_SLT,  32'hFFFF_FFFF, 32'd1,         32'd0,         32'd1},
      '{2'b11, F_SLT,  32'd1,         32'hFFFF_FFFF, 32'd0,         32'd0},
      '{2'b11, F_DIV,  32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD}
    };
    for (int i = 0; i < 12; i++) begin
      run_op(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, 1'b0, o);
      e = model(tbl[i].op, tbl[i].fn, tbl[i].a, tbl[i].b, 1'b1);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL directed[%0d]: got r=%h lat=%0d busy=%0d, need r=%h lat=%0d busy=%0d",
                 i, o.r, o.lat, o.busy, e.r, e.lat, e.busy);
      end
      n_vec++;
      if ({o.r.hi, o.r.lo} !== {tbl[i].hi, tbl[i].lo}) begin
        n_err++;
        $display("FAIL directed_const[%0d]: got hi=%h lo=%h, need hi=%h lo=%h",
                 i, o.r.hi, o.r.lo, tbl[i].hi, tbl[i].lo);
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    logic [5:0] fl [6];
    fl = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT};
    for (int i = 0; i < 10; i++) begin
      aluop = 2'($urandom_range(0, 3)); funct = fl[$urandom_range(0, 5)];
      a = pick(); b = pick(); valid = 1'b1;
      e = model(aluop, funct, a, b, 1'b1);
      @(posedge clk); #1;
      n_vec++;
      if ({ready, vo, ill, dz, zr, hi, res} !== {1'b1, e.r}) begin
        n_err++;
        $display("FAIL back_to_back[%0d]: got rdy=%b r=%h, need rdy=1 r=%h",
                 i, ready, {vo, ill, dz, zr, hi, res}, e.r);
      end
    end
    valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_stall_kill();
    exp_t e;
    int n, pulses;
    // valid_i held high with an ADD while a DIV is busy
    aluop = 2'b11; funct = F_DIV; a = 32'hFFFF_FF9C; b = 32'd7; valid = 1'b1;
    e = model(aluop, funct, a, b, 1'b1);
    @(posedge clk); #1;
    funct = F_ADD; a = 32'd1; b = 32'd2;
    n = 0;
    while (!vo && n < 100) begin @(posedge clk); #1; n++; end
    valid = 1'b0;
    n_vec++;
    if ({vo, ill, dz, zr, hi, res} !== e.r || n != W + 1) begin
      n_err++;
      $display("FAIL stall_div: got r=%h lat=%0d, need r=%h lat=%0d",
               {vo, ill, dz, zr, hi, res}, n, e.r, W + 1);
    end
    @(posedge clk); #1;
    n_vec++;
    if (vo !== 1'b0) begin
      n_err++;
      $display("FAIL stall_ignored_add: got valid_o=%b, need 0", vo);
    end
    // kill at CALC cycle 10
    aluop = 2'b11; funct = F_DIV; a = 32'd100; b = 32'd3; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 kill = 1'b1;
    @(posedge clk); #1;
    kill = 1'b0;
    n_vec++;
    if ({ready, vo} !== 2'b10) begin
      n_err++;
      $display("FAIL kill_calc: got ready=%b valid_o=%b, need 1 0", ready, vo);
    end
    pulses = 0;
    for (int k = 0; k < 40; k++) begin @(posedge clk); #1; if (vo) pulses++; end
    n_vec++;
    if (pulses != 0) begin
      n_err++;
      $display("FAIL kill_no_result: got %0d valid_o pulses, need 0", pulses);
    end
    // kill in IDLE blocks acceptance
    aluop = 2'b11; funct = F_ADD; a = 32'd1; b = 32'd1; valid = 1'b1; kill = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0; kill = 1'b0;
    n_vec++;
    if (vo !== 1'b0) begin
      n_err++;
      $display("FAIL kill_idle: got valid_o=%b, need 0", vo);
    end
  endtask

  task automatic test_illegal();
    exp_t o, e;
    logic [5:0] fl [4];
    fl = '{F_MUL, F_MULU, F_DIV, F_DIVU};
    for (int i = 0; i < 4; i++) begin
      run_op(2'b11, fl[i], 32'd6, 32'd3, 1'b1, o);
      e = model(2'b11, fl[i], 32'd6, 32'd3, 1'b0);
      n_vec++;
      if (o !== e || o.r.ill !== 1'b1 || o.busy != 0) begin
        n_err++;
        $display("FAIL nomuldiv[%0d]: got r=%h lat=%0d busy=%0d, need r=%h lat=%0d busy=%0d",
                 i, o.r, o.lat, o.busy, e.r, e.lat, e.busy);
      end
      // main instance took the same op as a real mul/div; let it drain
      repeat (W + 4) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_random();
    exp_t o, e;
    logic [1:0] op;
    logic [5:0] fn;
    logic [W-1:0] x, y;
    logic [5:0] fl [10];
    fl = '{F_ADD, F_SUB, F_AND, F_OR, F_XOR, F_SLT, F_MUL, F_MULU, F_DIV, F_DIVU};
    for (int i = 0; i < 200; i++) begin
      op = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 2)) : 2'b11;
      fn = ($urandom_range(0, 9) == 0) ? 6'($urandom) : fl[$urandom_range(0, 9)];
      x = pick(); y = pick();
      run_op(op, fn, x, y, 1'b0, o);
      e = model(op, fn, x, y, 1'b1);
      n_vec++;
      if (o !== e) begin
        n_err++;
        $display("FAIL random[%0d] op=%b fn=%b a=%h b=%h: got r=%h lat=%0d busy=%0d, need r=%h lat=%0d busy=%0d",
                 i, op, fn, x, y, o.r, o.lat, o.busy, e.r, e.lat, e.busy);
      end
    end
  endtask

  task automatic test_async_reset();
    exp_t o, e;
    aluop = 2'b11; funct = F_MUL; a = 32'd12345; b = 32'd678; valid = 1'b1;
    @(posedge clk); #1;
    valid = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_vec++;
    if ({ready, vo, ill, dz, zr, hi, res} !== {1'b1, 4'b0, 64'd0}) begin
      n_err++;
      $display("FAIL async_reset: got rdy=%b v=%b ill=%b dz=%b z=%b hi=%h res=%h, need rdy=1 rest 0",
               ready, vo, ill, dz, zr, hi, res);
    end
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_op(2'b11, F_ADD, 32'd40, 32'd2, 1'b0, o);
    e = model(2'b11, F_ADD, 32'd40, 32'd2, 1'b1);
    n_vec++;
    if (o !== e) begin
      n_err++;
      $display("FAIL after_reset_add: got r=%h lat=%0d busy=%0d, need r=%h lat=%0d busy=%0d",
               o.r, o.lat, o.busy, e.r, e.lat, e.busy);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_stall_kill();
    test_illegal();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
